timer_ctrl: RTL



---
 rtl/timer_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// Register-mapped timer controller: CTRL/LOAD/STATUS/EXPCNT window driving the timer's clear/arm strobes.
// Optional expiry counter is built only when TIMER_CTRL_EXPCNT_EN is defined; otherwise offset 0xC reads 0.
module timer_ctrl #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              timer_clr,
    output logic              set_timer,
    output logic [CNT_W-1:0]  timer_set_val,
    input  logic              timer_is_high,
    output logic              irq
);

    typedef enum logic [1:0] {IDLE, CLR, SET, WAIT} state_t;

    state_t           state_q;
    logic             en_q, per_q, ien_q, pending_q;
    logic [CNT_W-1:0] load_q, snap_q, expcnt_rd;
    logic [1:0]       sel;
    logic             wr_ctrl, wr_load, wr_stat, rd_req, expire;
    logic [31:0]      rd_val;

    assign sel     = addr[3:2];
    assign wr_ctrl = req & we & (sel == 2'd0);
    assign wr_load = req & we & (sel == 2'd1);
    assign wr_stat = req & we & (sel == 2'd2);
    assign rd_req  = req & ~we;
    assign expire  = (state_q == WAIT) & timer_is_high;
    assign irq     = pending_q & ien_q;

`ifdef TIMER_CTRL_EXPCNT_EN
    logic [CNT_W-1:0] expcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            expcnt_q <= '0;
        end else if (expire) begin
            expcnt_q <= expcnt_q + 1'b1;
        end
    end

    assign expcnt_rd = expcnt_q;
`else
    assign expcnt_rd = '0;
`endif

    always_comb begin
        rd_val = '0;
        case (sel)
            2'd0:    rd_val[2:0] = {ien_q, per_q, en_q};
            2'd1:    rd_val[CNT_W-1:0] = load_q;
            2'd2:    rd_val[1:0] = {state_q != IDLE, pending_q};
            default: rd_val[CNT_W-1:0] = expcnt_rd;
        endcase
    end

    // A CTRL write overrides whatever the FSM would have done this cycle;
    // expiry side effects on pending/EXPCNT still land.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            en_q          <= 1'b0;
            per_q         <= 1'b0;
            ien_q         <= 1'b0;
            pending_q     <= 1'b0;
            load_q        <= '0;
            snap_q        <= '0;
            rdata         <= '0;
            rvalid        <= 1'b0;
            timer_clr     <= 1'b0;
            set_timer     <= 1'b0;
            timer_set_val <= '0;
        end else begin
            timer_clr <= 1'b0;
            set_timer <= 1'b0;
            rvalid    <= rd_req;
            if (rd_req) begin
                rdata <= rd_val;
            end
            if (wr_load) begin
                load_q <= wdata[CNT_W-1:0];
            end
            if (wr_stat && wdata[0]) begin
                pending_q <= 1'b0;
            end
            if (expire) begin
                pending_q <= 1'b1;
            end
            if (wr_ctrl) begin
                en_q  <= wdata[0];
                per_q <= wdata[1];
                ien_q <= wdata[2];
                if (wdata[0]) begin
                    state_q   <= CLR;
                    timer_clr <= 1'b1;
                    snap_q    <= load_q;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    CLR: begin
                        state_q       <= SET;
                        set_timer     <= 1'b1;
                        timer_set_val <= snap_q;
                    end
                    SET: state_q <= WAIT;
                    WAIT: begin
                        if (timer_is_high) begin
                            if (per_q) begin
                                state_q   <= CLR;
                                timer_clr <= 1'b1;
                                snap_q    <= load_q;
                            end else begin
                                state_q <= IDLE;
                                en_q    <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
